// File: rtl/byte_ram_ctrl.sv
// Byte-wide RAM responder for the ALU memory req/ack handshake.
// Each 32-bit access is four little-endian byte operations.
module byte_ram_ctrl #(
  parameter int unsigned RAMSIZE   = 2048,
  parameter int unsigned ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          ramAddress,
  input  logic [31:0]          ramIn,
  input  logic                 readReq,
  input  logic                 writeReq,
  input  logic                 loadEn,
  input  logic [ADDR_BITS-1:0] loadAddr,
  input  logic [7:0]           loadData,
  output logic [31:0]          ramValue,
  output logic                 readAck,
  output logic                 writeAck,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_e;

  logic [7:0] mem [RAMSIZE];

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [23:0]           rbuf_q, rbuf_d;
  logic [31:0]           ramValue_q, ramValue_d;
  logic                  readAck_q, readAck_d;
  logic                  writeAck_q, writeAck_d;
  logic                  busy_q, busy_d;

  logic [ADDR_BITS-1:0]  baddr_c;
  logic [7:0]            rbyte_c;
  logic                  mem_we_c;
  logic [ADDR_BITS-1:0]  mem_waddr_c;
  logic [7:0]            mem_wdata_c;
  logic                  unused_addr_c;

  // Upper address bits are deliberately ignored; the store wraps.
  assign unused_addr_c = ^ramAddress[31:ADDR_BITS];
  assign baddr_c       = addr_q + ADDR_BITS'(cnt_q);
  assign rbyte_c       = mem[baddr_c];

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      rbuf_q     <= 24'd0;
      ramValue_q <= 32'd0;
      readAck_q  <= 1'b0;
      writeAck_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rbuf_q     <= rbuf_d;
      ramValue_q <= ramValue_d;
      readAck_q  <= readAck_d;
      writeAck_q <= writeAck_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: preload beats write, write beats read
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        if (!loadEn && (writeReq || readReq)) begin
          addr_d  = ramAddress[ADDR_BITS-1:0];
          wdata_d = ramIn;
          wr_d    = writeReq;
          cnt_d   = 2'd0;
          state_d = XFER;
        end
      end
      XFER: begin
        cnt_d  = cnt_q + 2'd1;
        rbuf_d = {rbyte_c, rbuf_q[23:8]};
        if (cnt_q == 2'd3) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and memory write port
  always_comb begin
    ramValue_d  = ramValue_q;
    readAck_d   = 1'b0;
    writeAck_d  = 1'b0;
    busy_d      = (state_d != IDLE);
    mem_we_c    = 1'b0;
    mem_waddr_c = loadAddr;
    mem_wdata_c = loadData;
    case (state_q)
      IDLE: mem_we_c = loadEn;
      XFER: begin
        if (wr_q) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = baddr_c;
          mem_wdata_c = 8'(wdata_q >> {cnt_q, 3'b000});
        end
        if (cnt_q == 2'd3) begin
          if (wr_q) begin
            writeAck_d = 1'b1;
          end else begin
            readAck_d  = 1'b1;
            ramValue_d = {rbyte_c, rbuf_q};
          end
        end
      end
      default: ;
    endcase
  end

  // Backing store is never cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  assign ramValue = ramValue_q;
  assign readAck  = readAck_q;
  assign writeAck = writeAck_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Scoreboard bench for byte_ram_ctrl: driver pushes expected acks, a
// negedge monitor pops and compares them.
module tb_byte_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ramAddress;
  logic [31:0] ramIn;
  logic        readReq, writeReq, loadEn;
  logic [10:0] loadAddr;
  logic [7:0]  loadData;
  logic [31:0] ramValue;
  logic        readAck, writeAck, busy;

  typedef struct packed {
    logic        is_read;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned ack_cycles[$];
  int unsigned cyc = 0;
  logic        prev_ack = 1'b0;
  int          checks = 0;
  int          failures = 0;

  byte_ram_ctrl #(.RAMSIZE(2048), .ADDR_BITS(11)) dut (
    .clk(clk), .reset(reset), .ramAddress(ramAddress), .ramIn(ramIn),
    .readReq(readReq), .writeReq(writeReq), .loadEn(loadEn),
    .loadAddr(loadAddr), .loadData(loadData), .ramValue(ramValue),
    .readAck(readAck), .writeAck(writeAck), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every ack must match the oldest expectation
  always @(negedge clk) begin
    if (readAck || writeAck) begin
      ack_cycles.push_back(cyc);
      chk("ack_width", 32'(prev_ack), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=%b%b required=none", readAck, writeAck);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ack_kind", 32'({readAck, writeAck}), e.is_read ? 32'd2 : 32'd1);
        if (e.is_read) chk("ramValue", ramValue, e.val);
      end
    end
    prev_ack <= readAck | writeAck;
  end

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(posedge clk); #1;
    loadEn = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_val);
    int n;
    exp_t e;
    e.is_read = rd && !wr;
    e.val     = exp_val;
    sb_q.push_back(e);
    @(posedge clk); #1;
    readReq = rd; writeReq = wr; ramAddress = a; ramIn = d;
    @(posedge clk);
    @(negedge clk);
    chk("busy_during_access", 32'(busy), 32'd1);
    n = 0;
    while (!(readAck || writeAck) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=no_ack required=ack_within_20");
    end
    @(posedge clk); #1;
    readReq = 1'b0; writeReq = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ramAddress = 32'd0; ramIn = 32'd0;
    readReq = 1'b0; writeReq = 1'b0; loadEn = 1'b0;
    loadAddr = 11'd0; loadData = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_readAck", 32'(readAck), 32'd0);
    chk("reset_writeAck", 32'(writeAck), 32'd0);
    chk("reset_ramValue", ramValue, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Preload then read back little-endian
    preload(11'd0, 8'h11); preload(11'd1, 8'h22);
    preload(11'd2, 8'h33); preload(11'd3, 8'h44);
    access(1, 0, 32'd0, 32'd0, 32'h44332211);

    // Held readReq: two reads, acks six cycles apart
    sb_q.push_back('{is_read: 1'b1, val: 32'h44332211});
    sb_q.push_back('{is_read: 1'b1, val: 32'h44332211});
    ack_cycles.delete();
    @(posedge clk); #1;
    readReq = 1'b1; ramAddress = 32'd0;
    repeat (12) @(posedge clk);
    #1 readReq = 1'b0;
    repeat (4) @(posedge clk);
    chk("held_read_ack_count", 32'(ack_cycles.size()), 32'd2);
    if (ack_cycles.size() >= 2)
      chk("held_read_ack_spacing", 32'(ack_cycles[1] - ack_cycles[0]), 32'd6);

    // Write then read, plus unaligned read spanning a preloaded byte
    preload(11'd12, 8'h5A);
    access(0, 1, 32'd8, 32'hDEADBEEF, 32'd0);
    access(1, 0, 32'd8, 32'd0, 32'hDEADBEEF);
    access(1, 0, 32'd9, 32'd0, 32'h5ADEADBE);

    // Wrap past the top of the store; upper address bits ignored
    access(0, 1, 32'd2046, 32'hA1B2C3D4, 32'd0);
    access(1, 0, 32'd2046, 32'd0, 32'hA1B2C3D4);
    access(1, 0, 32'hFFFF_F7FE, 32'd0, 32'hA1B2C3D4);
    access(1, 0, 32'd0, 32'd0, 32'h4433A1B2);

    // Simultaneous requests: write wins
    access(1, 1, 32'd16, 32'h12345678, 32'd0);
    access(1, 0, 32'd16, 32'd0, 32'h12345678);

    // Reset mid-write after two bytes landed
    preload(11'd32, 8'h00); preload(11'd33, 8'h00);
    preload(11'd34, 8'h00); preload(11'd35, 8'h00);
    @(posedge clk); #1;
    writeReq = 1'b1; ramAddress = 32'd32; ramIn = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; writeReq = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_writeAck", 32'(writeAck), 32'd0);
    chk("midreset_ramValue", ramValue, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    access(1, 0, 32'd32, 32'd0, 32'h0000FFFF);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
